pixel_frame_streamer: RTL and testbench
=======================================

// Module: pixel_frame_streamer
// PURPOSE
//   Parametrised successor of the pixel readout output stage. After a conversion, streams one
//   frame from the pixel buffer onto a valid/ready bus, OUTPUT_BUS_PIXEL_WIDTH pixels per beat,
//   with SOF/EOL/EOF framing and per-beat valid-pixel count.
//   Sits between the pixel array buffer (synchronous read port) and the off-chip output interface.
//   Unlike the fixed-clock DATA_OUT stream it replaces, it supports:
//   - backpressure;
//   - WIDTH not divisible by the bus width;
//   - overrun detection.
// PARAMETERS
//   WIDTH                  100  pixels per row
//   HEIGHT                 100  rows per frame
//   OUTPUT_BUS_PIXEL_WIDTH 10   pixels per output beat (OBPW)
//   BIT_DEPTH              10   bits per pixel (BD)
//   Derived (localparam, not overridable):
//   - BEATS = ceil(WIDTH/OBPW);
//   - AW = clog2(HEIGHT*BEATS);
//   - CW = clog2(OBPW+1).
// PORTS
//   SYSTEM_CLK            in   1        sole clock, rising edge
//   SYSTEM_RESET          in   1        asynchronous, active-low reset
//   FRAME_START           in   1        1-cycle pulse: conversion done, begin readout
//   FRAME_BUSY            out  1        high from accepted start until last beat handshaken
//   FRAME_DONE            out  1        1-cycle pulse after final beat accepted
//   FRAME_OVERRUN         out  1        1-cycle pulse: FRAME_START seen while busy
//   RD_EN                 out  1        buffer read strobe
//   RD_ADDR               out  AW       buffer word address = row*BEATS + beat
//   RD_DATA               in   OBPW*BD  buffer word, valid exactly 1 cycle after RD_EN
//   DATA_OUT_VALID        out  1        beat valid
//   DATA_OUT_READY        in   1        sink accepts beat
//   DATA_OUT              out  OBPW*BD  pixel k (col = beat*OBPW+k) at bits [k*BD +: BD]
//   DATA_OUT_SOF          out  1        first beat of frame
//   DATA_OUT_EOL          out  1        last beat of a row
//   DATA_OUT_EOF          out  1        last beat of frame (EOL also high)
//   DATA_OUT_PIXEL_COUNT  out  CW       number of valid pixels in beat
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - all outputs 0;
//   - FSM IDLE, read/beat counters 0, output buffer empty, outstanding read cleared.
//   FSM IDLE -> READ on FRAME_START. READ -> DRAIN after the last RD_EN issued.
//   DRAIN -> IDLE on handshake of the EOF beat.
//   - FRAME_DONE pulses, FRAME_BUSY falls on the same edge.
//   FRAME_START in READ/DRAIN: ignored for readout, FRAME_OVERRUN pulses next cycle.
//   FRAME_START on the same edge as IDLE return is also an overrun.
//   Reads:
//   - RD_EN high only in READ when (buffered beats + outstanding reads) < 2;
//   - RD_ADDR increments 0..HEIGHT*BEATS-1 per RD_EN;
//   - RD_DATA is captured into a 2-entry skid FIFO on the edge after RD_EN.
//   Latency, FRAME_START sampled at edge N:
//   - RD_EN/RD_ADDR=0 during cycle N..N+1;
//   - DATA_OUT_VALID first high after edge N+2.
//   Throughput: READY held high gives 1 beat/cycle, no bubbles after the first beat.
//   Handshake:
//   - beat transfers on edge with VALID&&READY;
//   - while VALID&&!READY, DATA_OUT and all flags hold stable;
//   - VALID never drops without a transfer.
//   Framing:
//   - SOF on beat 0;
//   - EOL when beat index mod BEATS = BEATS-1;
//   - EOF on beat HEIGHT*BEATS-1.
//   Last beat of each row:
//   - PIXEL_COUNT = WIDTH-(BEATS-1)*OBPW;
//   - pixels k >= PIXEL_COUNT forced to 0 regardless of RD_DATA.
//   All other beats: PIXEL_COUNT = OBPW.
//   Counters wrap to 0 at frame end, never mid-frame.
//   Reset mid-frame: frame abandoned, no FRAME_DONE; next FRAME_START restarts at address 0 with SOF.
// TESTING
//   Buffer model: word a, pixel k = (a*OBPW+k) mod 2^BD.
//   1) Defaults, READY=1, one FRAME_START:
//      - 1000 consecutive beats, RD_ADDR 0..999;
//      - SOF beat 0, EOL on beats 9,19,..., EOF+EOL on beat 999;
//      - FRAME_DONE 1 cycle after beat 999.
//   2) WIDTH=25, HEIGHT=4, OBPW=10:
//      - 12 beats, counts 10,10,5 per row;
//      - bits [99:50] of every 3rd beat are 0.
//   3) READY random 50%:
//      - beat sequence identical to (1), no drop/dup;
//      - DATA_OUT stable during every stall;
//      - never >2 reads outstanding+buffered.
//   4) FRAME_START at beat 500:
//      - FRAME_OVERRUN pulses once;
//      - frame completes unchanged with exactly one FRAME_DONE.
//   5) SYSTEM_RESET low at beat 300:
//      - all outputs 0 immediately, no FRAME_DONE;
//      - new FRAME_START gives RD_ADDR 0, SOF, full 1000-beat frame.
//   6) Back-to-back frames, FRAME_START on the cycle after FRAME_DONE:
//      - second frame starts cleanly, no overrun.

Source files
------------

// File: rtl/pixel_frame_streamer.sv
// rtl/pixel_frame_streamer.sv - streams one frame from the pixel buffer as framed valid/ready beats
module pixel_frame_streamer #(
   parameter int WIDTH = 100,
   parameter int HEIGHT = 100,
   parameter int OUTPUT_BUS_PIXEL_WIDTH = 10,
   parameter int BIT_DEPTH = 10,
   localparam int BEATS = (WIDTH + OUTPUT_BUS_PIXEL_WIDTH - 1) / OUTPUT_BUS_PIXEL_WIDTH,
   localparam int AW = (HEIGHT * BEATS > 1) ? $clog2(HEIGHT * BEATS) : 1,
   localparam int CW = $clog2(OUTPUT_BUS_PIXEL_WIDTH + 1),
   localparam int DW = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH
) (
   input  logic          SYSTEM_CLK,
   input  logic          SYSTEM_RESET,
   input  logic          FRAME_START,
   output logic          FRAME_BUSY,
   output logic          FRAME_DONE,
   output logic          FRAME_OVERRUN,
   output logic          RD_EN,
   output logic [AW-1:0] RD_ADDR,
   input  logic [DW-1:0] RD_DATA,
   output logic          DATA_OUT_VALID,
   input  logic          DATA_OUT_READY,
   output logic [DW-1:0] DATA_OUT,
   output logic          DATA_OUT_SOF,
   output logic          DATA_OUT_EOL,
   output logic          DATA_OUT_EOF,
   output logic [CW-1:0] DATA_OUT_PIXEL_COUNT
);

   localparam int OBPW     = OUTPUT_BUS_PIXEL_WIDTH;
   localparam int BD       = BIT_DEPTH;
   localparam int TOTAL    = HEIGHT * BEATS;
   localparam int LAST_CNT = WIDTH - (BEATS - 1) * OBPW;
   localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          rd_pend_q, rd_pend_d;
   logic [DW-1:0] fifo_mem_q [2];
   logic [DW-1:0] fifo_mem_d [2];
   logic          fifo_rptr_q, fifo_rptr_d;
   logic          fifo_wptr_q, fifo_wptr_d;
   logic [1:0]    fifo_cnt_q, fifo_cnt_d;
   logic [AW-1:0] out_idx_q, out_idx_d;
   logic [BW-1:0] col_q, col_d;
   logic          done_q, done_d;
   logic          overrun_q, overrun_d;

   logic          out_valid;
   logic          pop;
   logic          last_beat;
   logic          row_end;
   logic          last_read;
   logic [1:0]    used_slots;
   logic [DW-1:0] head;

   always_comb begin
      out_valid  = (fifo_cnt_q != 2'd0);
      pop        = out_valid && DATA_OUT_READY;
      last_beat  = (out_idx_q == AW'(TOTAL - 1));
      row_end    = (col_q == BW'(BEATS - 1));
      last_read  = (rd_addr_q == AW'(TOTAL - 1));
      // A slot freed by this cycle's handshake is reusable now, so a held-ready sink sees no bubbles.
      used_slots = fifo_cnt_q + 2'(rd_pend_q) - 2'(pop);
      RD_EN      = (state_q == S_READ) && (used_slots < 2'd2);
      head       = fifo_mem_q[fifo_rptr_q];

      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      rd_pend_d   = RD_EN;
      fifo_mem_d  = fifo_mem_q;
      fifo_rptr_d = fifo_rptr_q;
      fifo_wptr_d = fifo_wptr_q;
      fifo_cnt_d  = fifo_cnt_q + 2'(rd_pend_q) - 2'(pop);
      out_idx_d   = out_idx_q;
      col_d       = col_q;
      done_d      = 1'b0;
      overrun_d   = FRAME_START && (state_q != S_IDLE);

      case (state_q)
         S_IDLE:  if (FRAME_START) state_d = S_READ;
         S_READ:  if (RD_EN && last_read) state_d = S_DRAIN;
         S_DRAIN: if (pop && last_beat) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (RD_EN) rd_addr_d = last_read ? '0 : rd_addr_q + AW'(1);

      if (rd_pend_q) begin
         fifo_mem_d[fifo_wptr_q] = RD_DATA;
         fifo_wptr_d = ~fifo_wptr_q;
      end

      if (pop) begin
         fifo_rptr_d = ~fifo_rptr_q;
         out_idx_d   = last_beat ? '0 : out_idx_q + AW'(1);
         col_d       = row_end ? '0 : col_q + BW'(1);
         done_d      = last_beat;
      end
   end

   always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET) begin
      if (!SYSTEM_RESET) begin
         state_q       <= S_IDLE;
         rd_addr_q     <= '0;
         rd_pend_q     <= 1'b0;
         fifo_mem_q[0] <= '0;
         fifo_mem_q[1] <= '0;
         fifo_rptr_q   <= 1'b0;
         fifo_wptr_q   <= 1'b0;
         fifo_cnt_q    <= '0;
         out_idx_q     <= '0;
         col_q         <= '0;
         done_q        <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         rd_addr_q     <= rd_addr_d;
         rd_pend_q     <= rd_pend_d;
         fifo_mem_q    <= fifo_mem_d;
         fifo_rptr_q   <= fifo_rptr_d;
         fifo_wptr_q   <= fifo_wptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         out_idx_q     <= out_idx_d;
         col_q         <= col_d;
         done_q        <= done_d;
         overrun_q     <= overrun_d;
      end
   end

   always_comb begin
      DATA_OUT = '0;
      // Pixels past the right edge of the row are zeroed whatever the buffer word holds there.
      for (int k = 0; k < OBPW; k++) begin
         if (out_valid && (!row_end || k < LAST_CNT)) DATA_OUT[k*BD +: BD] = head[k*BD +: BD];
      end
      DATA_OUT_VALID       = out_valid;
      DATA_OUT_SOF         = out_valid && (out_idx_q == '0);
      DATA_OUT_EOL         = out_valid && row_end;
      DATA_OUT_EOF         = out_valid && last_beat;
      DATA_OUT_PIXEL_COUNT = !out_valid ? '0 : (row_end ? CW'(LAST_CNT) : CW'(OBPW));
      RD_ADDR              = rd_addr_q;
      FRAME_BUSY           = (state_q != S_IDLE);
      FRAME_DONE           = done_q;
      FRAME_OVERRUN        = overrun_q;
   end

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// tb/tb_pixel_frame_streamer.sv - scoreboard bench for pixel_frame_streamer (100x100 and 25x4 instances)
module tb_pixel_frame_streamer;

   typedef struct packed {
      logic [99:0] data;
      logic        sof;
      logic        eol;
      logic        eof;
      logic [3:0]  cnt;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        fs = 1'b0, busy, done, ovr, rd_en, vld, rdy = 1'b0, sof, eol, eof;
   logic [9:0]  rd_addr;
   logic [99:0] rd_data = '0, dout;
   logic [3:0]  cnt;

   logic        fs_s = 1'b0, busy_s, done_s, ovr_s, rd_en_s, vld_s, rdy_s = 1'b0, sof_s, eol_s, eof_s;
   logic [3:0]  rd_addr_s;
   logic [99:0] rd_data_s = '0, dout_s;
   logic [3:0]  cnt_s;

   int    n_checks = 0, n_pass = 0;
   beat_t exp_q[$], exp_s_q[$];
   beat_t cur, held, e, cur_s, e_s;
   bit    stall_prev = 0, bp_stop = 0;
   int    exp_rd_addr = 0, occ = 0, max_occ = 0, done_cnt = 0, ovr_cnt = 0, s_beats = 0;

   always #5 clk = ~clk;

   pixel_frame_streamer dut (
      .SYSTEM_CLK(clk), .SYSTEM_RESET(rst_n), .FRAME_START(fs), .FRAME_BUSY(busy),
      .FRAME_DONE(done), .FRAME_OVERRUN(ovr), .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
      .DATA_OUT_VALID(vld), .DATA_OUT_READY(rdy), .DATA_OUT(dout), .DATA_OUT_SOF(sof),
      .DATA_OUT_EOL(eol), .DATA_OUT_EOF(eof), .DATA_OUT_PIXEL_COUNT(cnt)
   );

   pixel_frame_streamer #(.WIDTH(25), .HEIGHT(4), .OUTPUT_BUS_PIXEL_WIDTH(10), .BIT_DEPTH(10)) dut_s (
      .SYSTEM_CLK(clk), .SYSTEM_RESET(rst_n), .FRAME_START(fs_s), .FRAME_BUSY(busy_s),
      .FRAME_DONE(done_s), .FRAME_OVERRUN(ovr_s), .RD_EN(rd_en_s), .RD_ADDR(rd_addr_s), .RD_DATA(rd_data_s),
      .DATA_OUT_VALID(vld_s), .DATA_OUT_READY(rdy_s), .DATA_OUT(dout_s), .DATA_OUT_SOF(sof_s),
      .DATA_OUT_EOL(eol_s), .DATA_OUT_EOF(eof_s), .DATA_OUT_PIXEL_COUNT(cnt_s)
   );

   function automatic logic [99:0] buf_word(input int a);
      logic [99:0] w;
      for (int k = 0; k < 10; k++) w[k*10 +: 10] = 10'((a * 10 + k) % 1024);
      return w;
   endfunction

   function automatic beat_t make_beat(input int i, input int width, input int height);
      beat_t b;
      int beats, col, keep;
      beats = (width + 9) / 10;
      col   = i % beats;
      keep  = (col == beats - 1) ? width - (beats - 1) * 10 : 10;
      b.data = '0;
      for (int k = 0; k < keep; k++) b.data[k*10 +: 10] = 10'((i * 10 + k) % 1024);
      b.sof = (i == 0);
      b.eol = (col == beats - 1);
      b.eof = (i == height * beats - 1);
      b.cnt = 4'(keep);
      return b;
   endfunction

   // Synchronous-read pixel buffers: word appears the cycle after the strobe.
   always @(posedge clk) begin
      if (rd_en) rd_data <= buf_word(int'(rd_addr));
      if (rd_en_s) rd_data_s <= buf_word(int'(rd_addr_s));
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 0;
            occ = 0;
         end else begin
            cur = '{dout, sof, eol, eof, cnt};
            if (stall_prev) begin
               n_checks++;
               if (vld !== 1'b1 || cur !== held)
                  $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h", vld, cur, held);
               else n_pass++;
            end
            if (occ > max_occ) max_occ = occ;
            if (rd_en) begin
               n_checks++;
               if (rd_addr !== 10'(exp_rd_addr))
                  $display("FAIL rd_addr: got %0d, required %0d", rd_addr, exp_rd_addr);
               else n_pass++;
               exp_rd_addr++;
               occ++;
            end
            if (vld && rdy) begin
               n_checks++;
               if (exp_q.size() == 0) $display("FAIL beat_unexpected: got %h, required no beat", cur);
               else begin
                  e = exp_q.pop_front();
                  if (cur !== e) $display("FAIL beat: got %h, required %h", cur, e);
                  else n_pass++;
               end
               occ--;
            end
            if (done) done_cnt++;
            if (ovr) ovr_cnt++;
            stall_prev = vld && !rdy;
            held = cur;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && vld_s && rdy_s) begin
            cur_s = '{dout_s, sof_s, eol_s, eof_s, cnt_s};
            n_checks++;
            if (exp_s_q.size() == 0) $display("FAIL small_beat_unexpected: got %h, required no beat", cur_s);
            else begin
               e_s = exp_s_q.pop_front();
               if (cur_s !== e_s) $display("FAIL small_beat: got %h, required %h", cur_s, e_s);
               else n_pass++;
            end
            s_beats++;
         end
      end
   end

   task automatic push_frame();
      for (int i = 0; i < 1000; i++) exp_q.push_back(make_beat(i, 100, 100));
      exp_rd_addr = 0;
   endtask

   task automatic pulse_start();
      fs = 1'b1;
      @(posedge clk); #1;
      fs = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit seen);
      seen = 0;
      for (int c = 0; c < bound; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_beats(input int target);
      int b = 0;
      for (int c = 0; c < 3000 && b < target; c++) begin
         @(negedge clk);
         if (vld && rdy) b++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, ovr, rd_en, rd_addr, vld, dout, sof, eol, eof, cnt} !== '0)
         $display("FAIL reset_outputs: got busy=%b vld=%b rd_en=%b addr=%0d, required all 0", busy, vld, rd_en, rd_addr);
      else n_pass++;
      n_checks++;
      if ({busy_s, done_s, ovr_s, rd_en_s, rd_addr_s, vld_s, dout_s, sof_s, eol_s, eof_s, cnt_s} !== '0)
         $display("FAIL reset_outputs_small: got busy=%b vld=%b rd_en=%b, required all 0", busy_s, vld_s, rd_en_s);
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_frame();
      int beats = 0, bubbles = 0, last_c = -10, done_c = -1, d0;
      bit busy_at_done = 1'b1;
      d0 = done_cnt;
      rdy = 1'b1;
      push_frame();
      pulse_start();
      n_checks++;
      if (rd_en !== 1'b1 || rd_addr !== 10'd0 || vld !== 1'b0)
         $display("FAIL latency_n: got rd_en=%b addr=%0d vld=%b, required 1 0 0", rd_en, rd_addr, vld);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (vld !== 1'b0) $display("FAIL latency_n1: got vld=%b, required 0", vld);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (vld !== 1'b1 || sof !== 1'b1) $display("FAIL latency_n2: got vld=%b sof=%b, required 1 1", vld, sof);
      else n_pass++;
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_c = c;
            busy_at_done = busy;
            break;
         end
         if (vld && rdy) begin
            beats++;
            last_c = c;
         end else if (beats < 1000) bubbles++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (beats !== 1000 || bubbles !== 0)
         $display("FAIL throughput: got beats=%0d bubbles=%0d, required 1000 0", beats, bubbles);
      else n_pass++;
      n_checks++;
      if (done_c !== last_c + 1 || busy_at_done !== 1'b0)
         $display("FAIL done_timing: got done_gap=%0d busy=%b, required 1 0", done_c - last_c, busy_at_done);
      else n_pass++;
      n_checks++;
      if (done_cnt - d0 !== 1 || exp_q.size() !== 0 || exp_rd_addr !== 1000)
         $display("FAIL frame_end: got dones=%0d left=%0d reads=%0d, required 1 0 1000", done_cnt - d0, exp_q.size(), exp_rd_addr);
      else n_pass++;
   endtask

   task automatic test_partial_width();
      bit seen = 0;
      rdy_s = 1'b1;
      for (int i = 0; i < 12; i++) exp_s_q.push_back(make_beat(i, 25, 4));
      fs_s = 1'b1;
      @(posedge clk); #1;
      fs_s = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done_s === 1'b1) begin
            seen = 1;
            break;
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (!seen || s_beats !== 12 || exp_s_q.size() !== 0)
         $display("FAIL partial_frame: got done=%b beats=%0d left=%0d, required 1 12 0", seen, s_beats, exp_s_q.size());
      else n_pass++;
   endtask

   task automatic test_backpressure();
      bit seen;
      int d0;
      d0 = done_cnt;
      max_occ = 0;
      bp_stop = 0;
      push_frame();
      pulse_start();
      fork
         begin
            while (!bp_stop) begin
               rdy = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
         end
         begin
            wait_done(6000, seen);
            bp_stop = 1;
         end
      join
      rdy = 1'b1;
      n_checks++;
      if (!seen || done_cnt - d0 !== 1 || exp_q.size() !== 0)
         $display("FAIL backpressure_frame: got done=%b dones=%0d left=%0d, required 1 1 0", seen, done_cnt - d0, exp_q.size());
      else n_pass++;
      n_checks++;
      if (max_occ > 2) $display("FAIL occupancy: got %0d, required <= 2", max_occ);
      else n_pass++;
   endtask

   task automatic test_overrun();
      bit seen;
      int d0, o0;
      d0 = done_cnt;
      o0 = ovr_cnt;
      rdy = 1'b1;
      push_frame();
      pulse_start();
      wait_beats(500);
      pulse_start();
      n_checks++;
      if (ovr !== 1'b1) $display("FAIL overrun_pulse: got %b, required 1", ovr);
      else n_pass++;
      wait_done(2000, seen);
      n_checks++;
      if (!seen || ovr_cnt - o0 !== 1 || done_cnt - d0 !== 1 || exp_q.size() !== 0 || exp_rd_addr !== 1000)
         $display("FAIL overrun_frame: got done=%b overruns=%0d dones=%0d left=%0d reads=%0d, required 1 1 1 0 1000",
                  seen, ovr_cnt - o0, done_cnt - d0, exp_q.size(), exp_rd_addr);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      bit seen;
      int d0;
      rdy = 1'b1;
      push_frame();
      pulse_start();
      wait_beats(300);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, ovr, rd_en, rd_addr, vld, dout, sof, eol, eof, cnt} !== '0)
         $display("FAIL midreset_outputs: got busy=%b vld=%b rd_en=%b addr=%0d, required all 0", busy, vld, rd_en, rd_addr);
      else n_pass++;
      exp_q.delete();
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_frame();
      pulse_start();
      n_checks++;
      if (rd_en !== 1'b1 || rd_addr !== 10'd0)
         $display("FAIL restart_addr: got rd_en=%b addr=%0d, required 1 0", rd_en, rd_addr);
      else n_pass++;
      wait_done(2000, seen);
      n_checks++;
      if (!seen || done_cnt - d0 !== 1 || exp_q.size() !== 0 || exp_rd_addr !== 1000)
         $display("FAIL restart_frame: got done=%b dones=%0d left=%0d reads=%0d, required 1 1 0 1000",
                  seen, done_cnt - d0, exp_q.size(), exp_rd_addr);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit seen1, seen2;
      int d0, o0;
      d0 = done_cnt;
      o0 = ovr_cnt;
      rdy = 1'b1;
      push_frame();
      pulse_start();
      wait_done(2000, seen1);
      push_frame();
      pulse_start();
      n_checks++;
      if (rd_en !== 1'b1 || rd_addr !== 10'd0)
         $display("FAIL b2b_start: got rd_en=%b addr=%0d, required 1 0", rd_en, rd_addr);
      else n_pass++;
      wait_done(2000, seen2);
      n_checks++;
      if (!seen1 || !seen2 || done_cnt - d0 !== 2 || ovr_cnt - o0 !== 0 || exp_q.size() !== 0)
         $display("FAIL b2b_frames: got done=%b%b dones=%0d overruns=%0d left=%0d, required 11 2 0 0",
                  seen1, seen2, done_cnt - d0, ovr_cnt - o0, exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_partial_width();
      test_backpressure();
      test_overrun();
      test_reset_mid_frame();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
